sseg_capture: RTL and testbench

SSEG_CAPTURE -- requirements
Module: sseg_capture

---
 rtl/sseg_pkg.sv | 57 +++++
 rtl/sseg_glyph_decode.sv | 19 +
 rtl/sseg_capture.sv | 127 ++++++++++++
 tb/tb_sseg_capture.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment capture block: FSM states,
// the sampled-pin bundle, and the active-low hex glyph table with its decoder.
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HELD = 2'd2
    } state_t;

    // One sample of the display pins as seen on the board (all active-low).
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } pins_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       err;
    } glyph_t;

    // Active-low segment patterns, seg[0]=a .. seg[6]=g, indexed by hex value.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Patterns outside the table decode to nibble 0 with the error flag set.
    function automatic glyph_t glyph_decode(input logic [6:0] seg);
        glyph_t g;
        g.nibble = 4'h0;
        g.err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (g.err && GLYPH_TABLE[i] == seg) begin
                g.nibble = 4'(i);
                g.err    = 1'b0;
            end
        end
        return g;
    endfunction

    // A strobe is usable only when exactly one digit enable is pulled low.
    function automatic logic strobe_legal(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic logic [1:0] strobe_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational segment-pattern to hex-nibble decoder.
module sseg_glyph_decode (
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);
    import sseg_pkg::*;

    glyph_t g;

    // Table lookup; unknown patterns flag an error.
    always_comb begin
        g = glyph_decode(seg);
    end

    assign nibble = g.nibble;
    assign err    = g.err;

endmodule

// File: rtl/sseg_capture.sv
// Snoops a multiplexed 4-digit seven-segment display and reassembles the
// shown hex value. A digit is accepted once its pins have been steady for
// STABLE_CYCLES samples; a frame is published once all four digits are seen.
module sseg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);
    import sseg_pkg::*;

    localparam logic [7:0] CNT_TARGET = 8'(STABLE_CYCLES);

    pins_t      cur, prev;
    state_t     state;
    logic [7:0] cnt, cnt_inc;
    logic       legal, changed, capture;
    logic [1:0] idx;
    logic [3:0] nibble;
    logic       err;

    logic [3:0][3:0] stage_val;
    logic [3:0]      stage_dp, stage_err, mask;

    // Pin sampling: one register stage plus the previous sample for comparison.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur  <= '1;
            prev <= '1;
        end else begin
            cur  <= '{an: an, seg: seg, dp: dp};
            prev <= cur;
        end
    end

    sseg_glyph_decode u_decode (
        .seg    (cur.seg),
        .nibble (nibble),
        .err    (err)
    );

    assign legal   = strobe_legal(cur.an);
    assign changed = (cur != prev);
    assign idx     = strobe_index(cur.an);
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    // The digit is taken on the very edge the counter reaches the target.
    assign capture = (state == QUAL) && legal && !changed && (cnt_inc == CNT_TARGET);

    // Qualification FSM: count steady samples, capture once, then wait for a change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (legal) begin
                        state <= QUAL;
                        cnt   <= 8'd1;
                    end
                end
                QUAL: begin
                    if (!legal) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (changed) begin
                        cnt <= 8'd1;
                    end else begin
                        cnt <= cnt_inc;
                        if (capture) state <= HELD;
                    end
                end
                HELD: begin
                    if (changed) begin
                        if (legal) begin
                            state <= QUAL;
                            cnt   <= 8'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Staging slots and frame publish; a capture on the publish edge starts the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_val   <= '0;
            stage_dp    <= '0;
            stage_err   <= '0;
            mask        <= '0;
            value       <= '0;
            dp_out      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (mask == 4'hF) begin
                value       <= stage_val;
                dp_out      <= stage_dp;
                digit_err   <= stage_err;
                frame_valid <= 1'b1;
            end
            if (capture) begin
                stage_val[idx] <= nibble;
                stage_dp[idx]  <= ~cur.dp;
                stage_err[idx] <= err;
            end
            mask <= ((mask == 4'hF) ? 4'h0 : mask) | (capture ? (4'b0001 << idx) : 4'h0);
        end
    end

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed scans with literal expectations plus a
// randomized pin stream, all checked every cycle against a run-length model.
module tb_sseg_capture;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    int tests = 0;
    int fails = 0;
    int dut_frames = 0;
    bit started = 0;

    sseg_capture #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .value       (value),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active-high gfedcba glyphs; the pins carry the inverse.
    function automatic logic [6:0] hi_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [4:0] tb_decode(input logic [6:0] s);
        for (int n = 0; n < 16; n++) begin
            logic [6:0] g;
            g = ~hi_glyph(4'(n));
            if (g == s) return {4'(n), 1'b0};
        end
        return {4'h0, 1'b1};
    endfunction

    function automatic int zeros(input logic [3:0] a);
        int z = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) z++;
        return z;
    endfunction

    function automatic int low_pos(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (!a[i]) return i;
        return 0;
    endfunction

    // Model: a digit is captured when its sample has repeated exactly S times.
    logic [3:0]  m_an = 4'hF;
    logic [6:0]  m_seg = 7'h7F;
    logic        m_dpin = 1'b1;
    int          m_run = 0;
    logic [3:0]  m_seen = 0;
    logic [15:0] st_val = 0;
    logic [3:0]  st_dp = 0, st_err = 0;
    bit          m_pend = 0;
    logic [15:0] p_val = 0;
    logic [3:0]  p_dp = 0, p_err = 0;
    logic [15:0] e_val = 0;
    logic [3:0]  e_dp = 0, e_err = 0;
    logic        e_fv = 0;

    initial forever begin
        @(posedge clk);
        started = 1;
        if (!rst_n) begin
            m_an = 4'hF; m_seg = 7'h7F; m_dpin = 1'b1; m_run = 0;
            m_seen = 0; st_val = 0; st_dp = 0; st_err = 0; m_pend = 0;
            e_val = 0; e_dp = 0; e_err = 0; e_fv = 0;
        end else begin
            e_fv = 0;
            if (m_pend) begin
                e_val = p_val; e_dp = p_dp; e_err = p_err; e_fv = 1; m_pend = 0;
            end
            if (zeros(m_an) == 1 && m_run == S) begin
                int d;
                logic [4:0] dec;
                d = low_pos(m_an);
                dec = tb_decode(m_seg);
                st_val[d*4 +: 4] = dec[4:1];
                st_err[d] = dec[0];
                st_dp[d] = ~m_dpin;
                m_seen[d] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_pend = 1; p_val = st_val; p_dp = st_dp; p_err = st_err; m_seen = 0;
                end
            end
            if (an == m_an && seg == m_seg && dp == m_dpin) begin
                if (m_run < 100000) m_run++;
            end else begin
                m_run = 1;
            end
            m_an = an; m_seg = seg; m_dpin = dp;
        end
    end

    // Cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            tests++;
            if ({value, dp_out, digit_err, frame_valid} !== {e_val, e_dp, e_err, e_fv}) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t: value=%h dp_out=%b err=%b fv=%b, expected value=%h dp_out=%b err=%b fv=%b",
                         $time, value, dp_out, digit_err, frame_valid, e_val, e_dp, e_err, e_fv);
            end
            if (frame_valid === 1'b1) dut_frames++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic show_raw(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an = a; seg = s; dp = d;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic show(input int pos, input logic [3:0] nib, input logic dpin, input int n);
        show_raw(~(4'b0001 << pos), ~hi_glyph(nib), dpin, n);
    endtask

    task automatic blank(input int n);
        show_raw(4'hF, 7'h7F, 1'b1, n);
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        rst_n = 1'b0; an = 4'hF; seg = 7'h7F; dp = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_value", 32'(value), 32'h0);
        check("reset_dp_out", 32'(dp_out), 32'h0);
        check("reset_digit_err", 32'(digit_err), 32'h0);
        check("reset_frame_valid", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;
        blank(3);

        // Plain scan 1,2,3,4
        f0 = dut_frames;
        show(3, 4'h1, 1'b1, 16); show(2, 4'h2, 1'b1, 16);
        show(1, 4'h3, 1'b1, 16); show(0, 4'h4, 1'b1, 16);
        blank(6);
        check("scan_frames", 32'(dut_frames - f0), 32'd1);
        check("scan_value", 32'(value), 32'h1234);
        check("scan_err", 32'(digit_err), 32'h0);

        // One sample short of qualifying: digit 0 must not count
        f0 = dut_frames;
        show(0, 4'h5, 1'b1, S - 1); blank(5);
        show(3, 4'h9, 1'b1, 8); show(2, 4'h6, 1'b1, 8); show(1, 4'h5, 1'b1, 8);
        blank(6);
        check("short_hold_no_frame", 32'(dut_frames - f0), 32'd0);
        show(0, 4'h7, 1'b1, 8); blank(6);
        check("short_hold_then_frame", 32'(dut_frames - f0), 32'd1);
        check("short_hold_value", 32'(value), 32'h9657);

        // Blank glyph on digit 2
        show(3, 4'hA, 1'b1, 8); show_raw(4'b1011, 7'h7F, 1'b1, 8);
        show(1, 4'h1, 1'b1, 8); show(0, 4'h8, 1'b1, 8);
        blank(6);
        check("bad_glyph_err", 32'(digit_err), 32'h4);
        check("bad_glyph_nibble", 32'(value[11:8]), 32'h0);
        check("bad_glyph_value", 32'(value), 32'hA018);

        // Two strobes low is blank; then F,A,0,8
        f0 = dut_frames;
        show_raw(4'b0011, ~hi_glyph(4'h3), 1'b1, 20);
        blank(4);
        check("multi_strobe_no_frame", 32'(dut_frames - f0), 32'd0);
        show(3, 4'hF, 1'b1, 8); show(2, 4'hA, 1'b1, 8);
        show(1, 4'h0, 1'b1, 8); show(0, 4'h8, 1'b1, 8);
        blank(6);
        check("fa08_value", 32'(value), 32'hFA08);
        check("fa08_frames", 32'(dut_frames - f0), 32'd1);

        // Reset mid-frame discards staged digits
        f0 = dut_frames;
        show(3, 4'h1, 1'b1, 8); show(2, 4'h2, 1'b1, 8); show(1, 4'h3, 1'b1, 8);
        pulse_reset(2);
        show(0, 4'h4, 1'b1, 8); blank(6);
        check("rst_no_frame", 32'(dut_frames - f0), 32'd0);
        check("rst_value", 32'(value), 32'h0);
        check("rst_dp_out", 32'(dp_out), 32'h0);
        check("rst_err", 32'(digit_err), 32'h0);
        show(3, 4'hC, 1'b1, 8); show(2, 4'hD, 1'b1, 8); show(1, 4'hE, 1'b1, 8);
        blank(6);
        check("rst_next_value", 32'(value), 32'hCDE4);

        // Decimal point on digit 1, long steady digit 0 captured once
        f0 = dut_frames;
        show(3, 4'h2, 1'b1, 8); show(2, 4'h7, 1'b1, 8); show(1, 4'h9, 1'b0, 8);
        show(0, 4'hB, 1'b1, 100);
        check("steady_frames", 32'(dut_frames - f0), 32'd1);
        check("dp_out_digit1", 32'(dp_out), 32'h2);
        check("dp_value", 32'(value), 32'h279B);
        show(3, 4'h2, 1'b1, 8); show(2, 4'h7, 1'b1, 8); show(1, 4'h9, 1'b1, 8);
        blank(6);
        check("steady_once", 32'(dut_frames - f0), 32'd1);
        show(0, 4'h6, 1'b1, 8); blank(6);
        check("steady_next_frame", 32'(dut_frames - f0), 32'd2);
        check("steady_next_dp", 32'(dp_out), 32'h0);

        // Random stream
        for (int k = 0; k < 400; k++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 99));
            len = int'($urandom_range(1, 2 * S + 3));
            if (kind < 3) begin
                pulse_reset(int'($urandom_range(1, 2)));
            end else if (kind < 70) begin
                logic [6:0] s;
                if ($urandom_range(0, 3) == 0) s = 7'($urandom);
                else s = ~hi_glyph(4'($urandom));
                show_raw(~(4'b0001 << $urandom_range(0, 3)), s, 1'($urandom), len);
            end else if (kind < 85) begin
                blank(len);
            end else begin
                show_raw(4'($urandom), 7'($urandom), 1'($urandom), len);
            end
        end
        blank(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
